// File: rtl/cp0_regfile_timed.sv
// Clocked CP0 for the 5-stage MIPS core: BadVAddr, Count, Compare, Status, Cause, EPC,
// with a Count/Compare timer, level hardware interrupts and a precise exception/ERET commit.
module cp0_regfile_timed #(
    parameter int          HW_INT_NUM = 6,
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] STATUS_RST = 32'h00400000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_exc_valid,
    input  logic [4:0]            i_exc_code,
    input  logic                  i_exc_in_ds,
    input  logic [31:0]           i_exc_pc,
    input  logic                  i_exc_badv_we,
    input  logic [31:0]           i_exc_badvaddr,
    input  logic                  i_eret,
    input  logic                  i_mtc0_we,
    input  logic [4:0]            i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic [4:0]            i_raddr,
    output logic [31:0]           o_rdata,
    input  logic [HW_INT_NUM-1:0] i_hw_int,
    output logic                  o_int_pending,
    output logic                  o_flush,
    output logic [31:0]           o_new_pc,
    output logic                  o_status_exl
);

    localparam logic [4:0]  A_BADVADDR = 5'd8;
    localparam logic [4:0]  A_COUNT    = 5'd9;
    localparam logic [4:0]  A_COMPARE  = 5'd11;
    localparam logic [4:0]  A_STATUS   = 5'd12;
    localparam logic [4:0]  A_CAUSE    = 5'd13;
    localparam logic [4:0]  A_EPC      = 5'd14;

    localparam logic [31:0] STATUS_WMASK = 32'h0000ff03;
    localparam logic [31:0] STATUS_BEV   = 32'h00400000;

    localparam int          DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [31:0]           r_badvaddr;
    logic [31:0]           r_count;
    logic [31:0]           r_compare;
    logic [31:0]           r_status;
    logic [31:0]           r_epc;
    logic [DIV_W-1:0]      r_div;
    logic                  r_cause_bd;
    logic                  r_cause_ti;
    logic [1:0]            r_ip_sw;
    logic [HW_INT_NUM-1:0] r_ip_hw;
    logic [4:0]            r_exccode;

    logic [5:0]            w_hw6;
    logic [7:0]            w_ip;
    logic [31:0]           w_cause;
    logic                  w_mtc0;
    logic                  w_timer_hit;
    logic                  w_div_wrap;

    // Hardware lines fill IP[2+HW_INT_NUM-1:2]; when all six are present the top line shares IP7 with TI.
    always_comb begin
        w_hw6                   = '0;
        w_hw6[HW_INT_NUM-1:0]   = r_ip_hw;
    end

    assign w_ip        = {w_hw6 | {r_cause_ti, 5'b0}, r_ip_sw};
    assign w_cause     = {r_cause_bd, r_cause_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};
    assign w_mtc0      = i_mtc0_we & ~i_exc_valid & ~i_eret;
    assign w_timer_hit = (r_count == r_compare) && (r_compare != 32'd0);
    assign w_div_wrap  = (r_div == DIV_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_badvaddr <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_status   <= STATUS_RST;
            r_epc      <= '0;
            r_div      <= '0;
            r_cause_bd <= 1'b0;
            r_cause_ti <= 1'b0;
            r_ip_sw    <= '0;
            r_ip_hw    <= '0;
            r_exccode  <= '0;
        end else begin
            r_ip_hw <= i_hw_int;

            if (w_mtc0 && i_waddr == A_COUNT) begin
                r_count <= i_wdata;
                r_div   <= '0;
            end else if (w_div_wrap) begin
                r_count <= r_count + 32'd1;
                r_div   <= '0;
            end else begin
                r_div   <= r_div + 1'b1;
            end

            if (w_mtc0 && i_waddr == A_COMPARE) begin
                r_compare  <= i_wdata;
                r_cause_ti <= 1'b0;
            end else if (w_timer_hit) begin
                r_cause_ti <= 1'b1;
            end

            if (i_exc_valid) begin
                // A nested exception keeps the original return point.
                if (!r_status[1]) begin
                    r_epc      <= i_exc_in_ds ? (i_exc_pc - 32'd4) : i_exc_pc;
                    r_cause_bd <= i_exc_in_ds;
                end
                r_status[1] <= 1'b1;
                r_exccode   <= i_exc_code;
                if (i_exc_badv_we)
                    r_badvaddr <= i_exc_badvaddr;
            end else if (i_eret) begin
                r_status[1] <= 1'b0;
            end else if (w_mtc0) begin
                case (i_waddr)
                    A_STATUS: r_status <= (r_status & ~STATUS_WMASK) | (i_wdata & STATUS_WMASK)
                                          | STATUS_BEV;
                    A_CAUSE:  r_ip_sw  <= i_wdata[9:8];
                    A_EPC:    r_epc    <= i_wdata;
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_raddr)
            A_BADVADDR: o_rdata = r_badvaddr;
            A_COUNT:    o_rdata = r_count;
            A_COMPARE:  o_rdata = r_compare;
            A_STATUS:   o_rdata = r_status;
            A_CAUSE:    o_rdata = w_cause;
            A_EPC:      o_rdata = r_epc;
            default:    o_rdata = '0;
        endcase
    end

    assign o_int_pending = r_status[0] & ~r_status[1] & (|(w_ip & r_status[15:8]));
    assign o_flush       = i_exc_valid | i_eret;
    assign o_new_pc      = i_exc_valid ? EXC_VECTOR : r_epc;
    assign o_status_exl  = r_status[1];

endmodule

// File: doc/cp0_regfile_timed.md
Name: cp0_regfile_timed

Overview:
Clocked, parametrised CP0 for the 5-stage MIPS core. Replaces the combinational CP0. Holds BadVAddr, Count, Compare, Status, Cause and EPC. Adds a Count/Compare timer interrupt, a parametrised number of hardware interrupt lines and a precise exception/ERET commit. Sits at the MEM/WB boundary and drives flush and redirect PC to the fetch stage.

Parameters:
HW_INT_NUM, 6, number of hardware interrupt inputs (1..6), mapped to Cause.IP[2+HW_INT_NUM-1:2]; unused IP bits read 0
EXC_VECTOR, 32'hbfc00380, redirect PC for every exception
COUNT_DIV, 2, core clocks per Count increment (>=1)
STATUS_RST, 32'h00400000, Status reset value (BEV=1)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
exc_valid  in  1  committing exception this cycle
exc_code  in  5  ExcCode (0 Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, 10 RI, 12 Ov)
exc_in_ds  in  1  faulting instruction is in a delay slot
exc_pc  in  32  PC of the faulting instruction
exc_badv_we  in  1  load BadVAddr (AdEL/AdES)
exc_badvaddr  in  32  faulting address
eret  in  1  ERET committing
mtc0_we  in  1  MTC0 committing
waddr  in  5  MTC0 register number
wdata  in  32  MTC0 data
raddr  in  5  MFC0 register number
rdata  out  32  MFC0 read data (combinational)
hw_int  in  HW_INT_NUM  level-sensitive hardware interrupts
int_pending  out  1  interrupt request to the pipeline
flush  out  1  pipeline flush
new_pc  out  32  redirect target
status_exl  out  1  Status.EXL

Behaviour:
- Registers and addresses: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. Other addresses read 0, and writes to them are ignored.
- Reset: all registers 0 except Status=STATUS_RST; divider counter 0. After reset with idle inputs: flush=0, int_pending=0, new_pc=EPC=0, status_exl=0.
- Write masks:
  - Status: only IM[15:8], EXL[1] and IE[0] are writable; BEV[22] is held at 1.
  - Cause: only IP[9:8] is writable.
  - BadVAddr: writes via MTC0 are ignored.
  - Count, Compare, EPC: fully writable.
- Read: rdata is combinational from register state as of the last edge. There is no same-cycle MTC0 bypass.
- Count:
  - Divider counts 0..COUNT_DIV-1. Count increments by 1 when the divider wraps; Count wraps from 0xFFFFFFFF to 0.
  - An MTC0 write to Count takes priority over the increment and clears the divider.
- Timer:
  - When the registered Count equals Compare and Compare != 0, Cause.TI[30] is set at the next edge.
  - An MTC0 write to Compare clears TI. If a write and a match occur in the same cycle, the write wins.
- Cause.IP:
  - IP[7] tracks TI.
  - IP[2+HW_INT_NUM-1:2] is a registered copy of hw_int, updated every cycle with 1-cycle latency.
- int_pending = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]). Combinational from registers.
- Exception commit (exc_valid=1), at the edge:
  - If EXL==0: EPC = exc_in_ds ? exc_pc-4 : exc_pc; Cause.BD[31] = exc_in_ds.
  - If EXL==1: EPC and BD are unchanged.
  - Always: EXL=1; Cause.ExcCode[6:2] = exc_code.
  - BadVAddr = exc_badvaddr if exc_badv_we.
- ERET (eret=1, exc_valid=0): EXL=0 at the edge.
- Priority within a cycle: exc_valid > eret > mtc0_we.
  - MTC0 is dropped whenever exc_valid or eret is high.
  - Timer and hw_int updates to Cause still occur alongside exceptions.
- flush = exc_valid | eret (combinational).
- new_pc = exc_valid ? EXC_VECTOR : EPC (current registered EPC).
- Reset mid-operation: rst overrides all events in that cycle.
- Widths: EPC subtraction is 32-bit modulo.

Test Plan:
- Reset, then read raddr=12, 13, 14 -> rdata 0x00400000, 0x00000000, 0x00000000; flush=0; int_pending=0.
- exc_valid, exc_code=8, exc_in_ds=1, exc_pc=0xbfc00104 -> same cycle flush=1, new_pc=0xbfc00380. Next cycle EPC=0xbfc00100, Cause=0x80000020, status_exl=1. Then eret -> new_pc=0xbfc00100, flush=1; EXL=0 after the edge.
- With EXL=1, exc_valid, exc_code=4, exc_badv_we=1, exc_badvaddr=0x00000003, exc_pc=0x80001000 -> BadVAddr=0x00000003, ExcCode=4, EPC unchanged.
- COUNT_DIV=2. MTC0 Compare=5, then Count=0, then Status=0x00408001 (IE, IM7) -> Count reaches 5 after 10 cycles; next cycle Cause[30]=1 and int_pending=1. MTC0 Compare=100 -> TI=0, int_pending=0.
- HW_INT_NUM=6, hw_int=6'b000001, Status=0x00400401 -> Cause[10]=1 one cycle later, then int_pending=1. Drop hw_int -> cleared one cycle later.
- Same cycle: exc_valid (code 12, pc 0x80000010) and mtc0_we to EPC with 0x12345678 -> EPC=0x80000010 and the MTC0 is dropped. MTC0 to Status with 0xFFFFFFFF -> rdata=0x0040FF03.
